// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding and default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the fetch unit: sequential, taken branch or jump target.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] br_off;
  logic [31:0] target;
  logic        unused_bits;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    target = pc_plus4;
    // An X control from an illegal opcode evaluates false here and falls through to pc_plus4.
    if (i_jump) begin
      target = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (i_branch && i_zero) begin
      target = pc_plus4 + br_off;
    end
  end

  assign next_pc     = {target[31:2], 2'b00};
  assign unused_bits = ^{instr[31:26], target[1:0]};

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack handshake and instruction register.
// Define FETCH_PERF_CNT_EN to add retire and memory-wait counters.
module imem_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [5:0]  o_op,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] o_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] o_retire_cnt,
  output logic [31:0] o_wait_cnt,
`endif
  output logic [31:0] o_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, instr_q;
  logic [31:0]  next_pc, pc_plus4;
  logic         capture, retire;

  next_pc_calc u_next_pc_calc (
    .pc       (pc_q),
    .instr    (instr_q),
    .i_branch (i_branch),
    .i_jump   (i_jump),
    .i_zero   (i_zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (i_imem_ack) begin
          state_d = FS_ISSUE;
          capture = 1'b1;
        end
      end
      FS_ISSUE: begin
        if (i_instr_ready) begin
          state_d = FS_REQ;
          retire  = 1'b1;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (capture) instr_q <= i_imem_rdata;
      if (retire)  pc_q    <= next_pc;
    end
  end

  assign o_imem_req    = (state_q == FS_REQ);
  assign o_instr_valid = (state_q == FS_ISSUE);
  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_plus4;
  assign o_instr       = instr_q;
  assign o_op          = instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retire_cnt_q, wait_cnt_q;
  logic        mem_wait;

  assign mem_wait = (state_q == FS_REQ) && !i_imem_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retire_cnt_q <= 32'd0;
      wait_cnt_q   <= 32'd0;
    end else begin
      if (retire)   retire_cnt_q <= retire_cnt_q + 32'd1;
      if (mem_wait) wait_cnt_q   <= wait_cnt_q + 32'd1;
    end
  end

  assign o_retire_cnt = retire_cnt_q;
  assign o_wait_cnt   = wait_cnt_q;
`endif

endmodule
